// File: rtl/delay_line.sv
// Fixed-latency delay line: delays `in` by LENGTH enabled clock edges, built either
// as a register chain or as a block-RAM ring buffer with a zero-forcing fill counter.
module delay_line #(
    parameter int    LENGTH = 10,
    parameter int    WIDTH  = 8,
    parameter string TYPE   = "CELLS"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    generate
        if ((TYPE != "CELLS" && TYPE != "ALTERA_BLOCK_RAM") || LENGTH < 0 || WIDTH < 1) begin : g_bad_cfg
            $fatal(1, "delay_line: unsupported configuration TYPE=%s LENGTH=%0d WIDTH=%0d",
                   TYPE, LENGTH, WIDTH);
            assign out = '0;
        end else if (LENGTH == 0) begin : g_wire
            // Zero-length delay is a pure wire; the control inputs have nothing to act on.
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst ^ ena;
            assign out = in;
        end else if (TYPE == "CELLS" || LENGTH == 1) begin : g_cells
            logic [WIDTH-1:0] stage_q [LENGTH];
            logic [WIDTH-1:0] stage_d [LENGTH];

            always_comb begin
                stage_d = stage_q;
                if (ena) begin
                    stage_d[0] = in;
                    for (int i = 1; i < LENGTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LENGTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign out = stage_q[LENGTH-1];
        end else begin : g_ram
            // The registered RAM read is itself the final delay stage, so the array
            // only needs LENGTH-1 words.
            localparam int D  = LENGTH - 1;
            localparam int AW = (D > 1) ? $clog2(D) : 1;
            localparam int CW = $clog2(D + 1);
            localparam logic [AW-1:0] WP_LAST   = AW'(D - 1);
            localparam logic [CW-1:0] FILL_FULL = CW'(D);

            logic [WIDTH-1:0] mem [D];
            logic [AW-1:0]    wp_q, wp_d;
            logic [CW-1:0]    fill_q, fill_d;
            logic [WIDTH-1:0] out_q, out_d;

            always_comb begin
                wp_d   = wp_q;
                fill_d = fill_q;
                out_d  = out_q;
                if (ena) begin
                    wp_d = (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
                    // Until D words have been written the RAM may hold stale or
                    // uninitialised data, so the output is forced to zero.
                    if (fill_q < FILL_FULL) begin
                        fill_d = fill_q + 1'b1;
                        out_d  = '0;
                    end else begin
                        out_d  = mem[wp_q];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wp_q   <= '0;
                    fill_q <= '0;
                    out_q  <= '0;
                end else begin
                    wp_q   <= wp_d;
                    fill_q <= fill_d;
                    out_q  <= out_d;
                end
            end

            always_ff @(posedge clk) begin
                if (ena) begin
                    mem[wp_q] <= in;
                end
            end

            assign out = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_delay_line.sv
// Directed bench for delay_line: register-chain and RAM variants side by side plus
// the LENGTH=0/1/2 boundary builds, all fed from one shared stimulus.
`timescale 1ns/100ps
module tb_delay_line;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] din;
    logic [7:0] o_c10, o_r10, o_l0, o_c1, o_r1, o_c2, o_r2;

    int passes = 0;
    int checks = 0;
    logic [7:0] hist [$];

    delay_line #(.LENGTH(10), .WIDTH(8), .TYPE("CELLS"))
        u_c10 (.clk(clk), .rst(rst), .ena(ena), .in(din), .out(o_c10));
    delay_line #(.LENGTH(10), .WIDTH(8), .TYPE("ALTERA_BLOCK_RAM"))
        u_r10 (.clk(clk), .rst(rst), .ena(ena), .in(din), .out(o_r10));
    delay_line #(.LENGTH(0), .WIDTH(8), .TYPE("CELLS"))
        u_l0 (.clk(clk), .rst(rst), .ena(ena), .in(din), .out(o_l0));
    delay_line #(.LENGTH(1), .WIDTH(8), .TYPE("CELLS"))
        u_c1 (.clk(clk), .rst(rst), .ena(ena), .in(din), .out(o_c1));
    delay_line #(.LENGTH(1), .WIDTH(8), .TYPE("ALTERA_BLOCK_RAM"))
        u_r1 (.clk(clk), .rst(rst), .ena(ena), .in(din), .out(o_r1));
    delay_line #(.LENGTH(2), .WIDTH(8), .TYPE("CELLS"))
        u_c2 (.clk(clk), .rst(rst), .ena(ena), .in(din), .out(o_c2));
    delay_line #(.LENGTH(2), .WIDTH(8), .TYPE("ALTERA_BLOCK_RAM"))
        u_r2 (.clk(clk), .rst(rst), .ena(ena), .in(din), .out(o_r2));

    // 200 MHz
    initial begin
        clk = 1'b0;
        forever #2.5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Word sampled L enabled edges ago (counting the latest edge as the first), else 0.
    function automatic logic [7:0] exp_of(input int len);
        if (hist.size() >= len) return hist[hist.size() - len];
        return 8'h00;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_c10"}, o_c10, 8'h00);
        check({tag, "_r10"}, o_r10, 8'h00);
        check({tag, "_c1"},  o_c1,  8'h00);
        check({tag, "_r1"},  o_r1,  8'h00);
        check({tag, "_c2"},  o_c2,  8'h00);
        check({tag, "_r2"},  o_r2,  8'h00);
    endtask

    task automatic step(input logic [7:0] v, input logic e);
        @(negedge clk);
        din = v;
        ena = e;
        #1 check("l0_comb", o_l0, v);
        @(posedge clk);
        if (e && !rst) hist.push_back(v);
        #1;
        check("c10", o_c10, exp_of(10));
        check("r10", o_r10, exp_of(10));
        check("r10_vs_c10", o_r10, o_c10);
        check("c1", o_c1, exp_of(1));
        check("r1", o_r1, exp_of(1));
        check("c2", o_c2, exp_of(2));
        check("r2", o_r2, exp_of(2));
    endtask

    // 5 ns pulse starting mid-cycle, held across one rising edge with ena high.
    task automatic pulse_reset();
        @(negedge clk);
        ena = 1'b1;
        #1 rst = 1'b1;
        hist.delete();
        #1 check_all_zero("rst_async");
        #2 check_all_zero("rst_held");
        #2 rst = 1'b0;
        ena = 1'b0;
    endtask

    initial begin
        logic [7:0] cnt;
        rst = 1'b1;
        ena = 1'b0;
        din = 8'h00;
        #1 check_all_zero("por");
        #2 rst = 1'b0;

        // Reset pulse, then an impulse on e0
        step(8'h3C, 1'b1);
        step(8'h4D, 1'b1);
        pulse_reset();
        for (int k = 0; k < 13; k++) begin
            step((k == 0) ? 8'hA5 : 8'h00, 1'b1);
            check("imp_c10", o_c10, (k == 9) ? 8'hA5 : 8'h00);
            check("imp_r10", o_r10, (k == 9) ? 8'hA5 : 8'h00);
            check("imp_c1",  o_c1,  (k == 0) ? 8'hA5 : 8'h00);
            check("imp_r1",  o_r1,  (k == 0) ? 8'hA5 : 8'h00);
            check("imp_r2",  o_r2,  (k == 1) ? 8'hA5 : 8'h00);
        end

        // Random stream across many RAM wraps
        for (int i = 0; i < 2000; i++) begin
            step(8'($urandom), 1'b1);
        end

        // Enable gaps: 4 enabled, 3 disabled with garbage on the input
        pulse_reset();
        cnt = 8'd0;
        for (int i = 0; i < 70; i++) begin
            if ((i % 7) < 4) begin
                step(cnt, 1'b1);
                cnt++;
            end else begin
                step(8'hEE, 1'b0);
            end
        end
        check("gap_c10_last", o_c10, 8'd30);
        check("gap_r10_last", o_r10, 8'd30);

        // Reset mid-stream: stale RAM words must not leak
        for (int i = 0; i < 50; i++) begin
            step(8'($urandom) | 8'h01, 1'b1);
        end
        pulse_reset();
        for (int k = 0; k < 12; k++) begin
            step(8'h60 + 8'(k), 1'b1);
            check("mid_r10", o_r10, (k >= 9) ? 8'h60 + 8'(k - 9) : 8'h00);
        end

        // Short directed burst for the boundary lengths
        step(8'h11, 1'b1);
        step(8'h22, 1'b1);
        check("bnd_c1", o_c1, 8'h22);
        check("bnd_r2", o_r2, 8'h11);
        step(8'h33, 1'b0);
        check("bnd_r2_hold", o_r2, 8'h11);
        step(8'h44, 1'b1);
        check("bnd_r2_next", o_r2, 8'h22);
        check("bnd_r1_next", o_r1, 8'h44);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
